regbank_wb_scheduler: RTL and testbench

- Schedules all writebacks into the single write port of the 32x32 register bank (rd / enable / data_i) and tracks which registers have writes still outstanding.
- Several producers (ALU, load unit, multi-cycle mul/div) compete for that port. The block arbitrates round-robin and drives a registered write.
- A per-register pending-write scoreboard gives decode rs1/rs2 hazard flags and gates instruction issue.

---
 rtl/regbank_wb_scheduler_pkg.sv | 11 +
 rtl/regbank_wb_scheduler_rr_arbiter.sv | 42 ++++
 rtl/regbank_wb_scheduler.sv | 118 +++++++++++
 tb/tb_regbank_wb_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_wb_scheduler_pkg.sv
// regbank_wb_scheduler_pkg: shared register-bank geometry and writeback request type.
package regbank_wb_scheduler_pkg;
    localparam int REG_IDX_W = 5;
    localparam int REG_NUM   = 32;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_req_t;
endpackage

// File: rtl/regbank_wb_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with a registered rotating priority pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PW-1:0]      grant_idx_o,
    output logic               grant_any_o
);
    logic [PW-1:0] ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0] gidx;
    logic found;

    always_comb begin
        gnt   = '0;
        gidx  = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [PW-1:0] i_w;
            i_w = PW'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_i[i_w]) begin
                found    = 1'b1;
                gidx     = i_w;
                gnt[i_w] = 1'b1;
            end
        end
    end

    assign ptr_d       = !found ? ptr_q : (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    assign grant_o     = gnt;
    assign grant_idx_o = gidx;
    assign grant_any_o = found;

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/regbank_wb_scheduler.sv
// regbank_wb_scheduler: arbitrates writebacks onto the regbank write port and tracks pending writes.
// Optional WB_BYPASS_EN adds commit-cycle forwarding outputs fwd1_data_o/fwd2_data_o.
module regbank_wb_scheduler
    import regbank_wb_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*REG_IDX_W-1:0]  req_rd_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          issue_valid_i,
    input  logic [REG_IDX_W-1:0]          issue_rd_i,
    output logic                          issue_ready_o,
    input  logic [REG_IDX_W-1:0]          rs1_i,
    input  logic [REG_IDX_W-1:0]          rs2_i,
    output logic                          hazard1_o,
    output logic                          hazard2_o,
`ifdef WB_BYPASS_EN
    output logic [DATA_W-1:0]             fwd1_data_o,
    output logic [DATA_W-1:0]             fwd2_data_o,
`endif
    output logic                          wr_enable_o,
    output logic [REG_IDX_W-1:0]          wr_rd_o,
    output logic [DATA_W-1:0]             wr_data_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    wb_req_t req [NUM_REQ];
    wb_req_t sel;
    logic [PW-1:0] gidx;
    logic gany;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign req[g] = '{rd: req_rd_i[g*REG_IDX_W +: REG_IDX_W], data: req_data_i[g*DATA_W +: DATA_W]};
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_valid_i),
        .grant_o     (req_ready_o),
        .grant_idx_o (gidx),
        .grant_any_o (gany)
    );

    assign sel = req[gidx];

    logic                 wr_en_q, wr_en_d;
    logic [REG_IDX_W-1:0] wr_rd_q, wr_rd_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic [CNT_W-1:0]     cnt_q [REG_NUM];
    logic [CNT_W-1:0]     cnt_d [REG_NUM];

    // rd=0 grants are consumed but never enable the regbank
    always_comb begin
        wr_en_d   = gany & (sel.rd != '0);
        wr_rd_d   = gany ? sel.rd : wr_rd_q;
        wr_data_d = gany ? sel.data : wr_data_q;
    end

    assign issue_ready_o = (issue_rd_i == '0) | (cnt_q[issue_rd_i] != CNT_MAX) |
                           (wr_en_q & (wr_rd_q == issue_rd_i));

    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            logic inc, dec;
            inc = issue_valid_i & issue_ready_o & (issue_rd_i == REG_IDX_W'(r)) & (r != 0);
            dec = wr_en_q & (wr_rd_q == REG_IDX_W'(r));
            cnt_d[r] = (r == 0) ? '0 :
                       (inc & ~dec) ? cnt_q[r] + 1'b1 :
                       (dec & ~inc & (cnt_q[r] != '0)) ? cnt_q[r] - 1'b1 : cnt_q[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            cnt_q     <= '{default: '0};
        end else begin
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

`ifndef SYNTH
    always_ff @(posedge clk) begin
        if (!reset && wr_en_q && cnt_q[wr_rd_q] == '0)
            $error("regbank_wb_scheduler: commit to x%0d with no outstanding write", wr_rd_q);
    end
`endif

    logic byp1, byp2;
`ifdef WB_BYPASS_EN
    // last outstanding write is committing now: hand its data straight to decode
    assign byp1 = (cnt_q[rs1_i] == CNT_W'(1)) & wr_en_q & (wr_rd_q == rs1_i);
    assign byp2 = (cnt_q[rs2_i] == CNT_W'(1)) & wr_en_q & (wr_rd_q == rs2_i);
    assign fwd1_data_o = byp1 ? wr_data_q : '0;
    assign fwd2_data_o = byp2 ? wr_data_q : '0;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign hazard1_o   = (rs1_i != '0) & (cnt_q[rs1_i] != '0) & ~byp1;
    assign hazard2_o   = (rs2_i != '0) & (cnt_q[rs2_i] != '0) & ~byp2;
    assign wr_enable_o = wr_en_q;
    assign wr_rd_o     = wr_rd_q;
    assign wr_data_o   = wr_data_q;
endmodule

// File: tb/tb_regbank_wb_scheduler.sv
// tb_regbank_wb_scheduler: directed stimulus with a queued write scoreboard and a decoupled write-port monitor.
module tb_regbank_wb_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [4:0]  rd_a [3];
    logic [31:0] dat_a [3];
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic [4:0]  rs1 = '0, rs2 = '0;
    logic        hz1, hz2;
    logic        wr_enable;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
`ifdef WB_BYPASS_EN
    logic [31:0] fwd1, fwd2;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_pack
        assign req_rd[g*5 +: 5]    = rd_a[g];
        assign req_data[g*32 +: 32] = dat_a[g];
    end

    regbank_wb_scheduler #(.NUM_REQ(3), .CNT_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_rd_i      (req_rd),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .issue_ready_o (issue_ready),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .hazard1_o     (hz1),
        .hazard2_o     (hz2),
`ifdef WB_BYPASS_EN
        .fwd1_data_o   (fwd1),
        .fwd2_data_o   (fwd2),
`endif
        .wr_enable_o   (wr_enable),
        .wr_rd_o       (wr_rd),
        .wr_data_o     (wr_data)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int cyc = 0;
    int nchk = 0;
    int nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && wr_enable === 1'b1) begin
            if (q.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_write: got x%0d=%h expected no write (t=%0t)", wr_rd, wr_data, $time);
            end else begin
                me = q.pop_front();
                chk("wr_rd", {27'b0, wr_rd}, {27'b0, me.rd});
                chk("wr_data", wr_data, me.data);
                chk("wr_cycle", cyc, me.cyc);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] v, input logic [2:0] er);
        req_valid = v;
        #1;
        chk("req_ready", {29'b0, req_ready}, {29'b0, er});
        for (int i = 0; i < 3; i++)
            if (er[i] && rd_a[i] != 5'd0) q.push_back('{rd_a[i], dat_a[i], cyc + 1});
    endtask

    task automatic iss(input logic [4:0] r);
        issue_valid = 1'b1;
        issue_rd = r;
        #1;
        chk("issue_ready", {31'b0, issue_ready}, 32'd1);
        tick;
        issue_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rd_a[i] = '0;
            dat_a[i] = '0;
        end
        repeat (2) tick;
        reset = 1'b0;
        #1;
        chk("rst_wr_enable", {31'b0, wr_enable}, 32'd0);
        chk("rst_wr_rd", {27'b0, wr_rd}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_ready", {29'b0, req_ready}, 32'd0);
        chk("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
        chk("rst_hz1", {31'b0, hz1}, 32'd0);
        chk("rst_hz2", {31'b0, hz2}, 32'd0);
        tick;

        // round-robin over three simultaneous requesters
        iss(5); iss(6); iss(7);
        rd_a = '{5'd5, 5'd6, 5'd7};
        dat_a = '{32'h0000_0055, 32'h0000_0066, 32'h0000_0077};
        req(3'b111, 3'b001); tick;
        req(3'b110, 3'b010); tick;
        req(3'b100, 3'b100); tick;
        req_valid = '0;
        tick;

        // two outstanding writes to x10
        iss(10); iss(10);
        rs1 = 5'd10;
        #1 chk("hz1_x10_cnt2", {31'b0, hz1}, 32'd1);
        rd_a[1] = 5'd10; dat_a[1] = 32'hDEAD_BEEF;
        req(3'b010, 3'b010); tick;
        req_valid = '0;
        #1 chk("hz1_x10_commit1", {31'b0, hz1}, 32'd1);
        tick;
        #1 chk("hz1_x10_cnt1", {31'b0, hz1}, 32'd1);
        rd_a[2] = 5'd10; dat_a[2] = 32'h0BAD_F00D;
        req(3'b100, 3'b100); tick;
        req_valid = '0;
        #1;
`ifdef WB_BYPASS_EN
        chk("hz1_x10_bypass", {31'b0, hz1}, 32'd0);
        chk("fwd1_x10", fwd1, 32'h0BAD_F00D);
`else
        chk("hz1_x10_commit2", {31'b0, hz1}, 32'd1);
`endif
        tick;
        #1 chk("hz1_x10_clear", {31'b0, hz1}, 32'd0);
`ifdef WB_BYPASS_EN
        chk("fwd1_idle", fwd1, 32'd0);
`endif

        // saturate x3 and release via same-cycle commit
        rs1 = 5'd3;
        iss(3); iss(3); iss(3);
        issue_valid = 1'b1; issue_rd = 5'd3;
        #1 chk("issue_full", {31'b0, issue_ready}, 32'd0);
        chk("hz1_x3", {31'b0, hz1}, 32'd1);
        tick;
        #1 chk("issue_full_hold", {31'b0, issue_ready}, 32'd0);
        rd_a[0] = 5'd3; dat_a[0] = 32'h0000_0033;
        req(3'b001, 3'b001); tick;
        req_valid = '0;
        #1 chk("issue_ready_commit", {31'b0, issue_ready}, 32'd1);
        tick;
        #1 chk("issue_full_again", {31'b0, issue_ready}, 32'd0);
        issue_rd = 5'd0;
        #1 chk("issue_rd0_ready", {31'b0, issue_ready}, 32'd1);
        tick;
        issue_valid = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0;
        #1 chk("hz1_rs0", {31'b0, hz1}, 32'd0);
        chk("hz2_rs0", {31'b0, hz2}, 32'd0);

        // rd=0 grant is consumed without a write and still rotates the pointer
        rd_a[1] = 5'd0; dat_a[1] = 32'h1234_5678;
        req(3'b010, 3'b010); tick;
        req_valid = '0;
        #1 chk("rd0_no_enable", {31'b0, wr_enable}, 32'd0);
        chk("hz1_rs0_after", {31'b0, hz1}, 32'd0);
        iss(20); iss(21);
        rd_a[0] = 5'd20; dat_a[0] = 32'h0000_0020;
        rd_a[1] = 5'd21; dat_a[1] = 32'h0000_0021;
        req(3'b011, 3'b001); tick;
        req(3'b010, 3'b010); tick;
        req_valid = '0;
        tick;

        // issue and commit to x9 in the same cycle
        iss(9);
        rd_a[2] = 5'd9; dat_a[2] = 32'h0000_0099;
        req(3'b100, 3'b100); tick;
        req_valid = '0;
        issue_valid = 1'b1; issue_rd = 5'd9; rs2 = 5'd9;
        #1 chk("issue_x9_commit", {31'b0, issue_ready}, 32'd1);
`ifdef WB_BYPASS_EN
        chk("hz2_x9_bypass", {31'b0, hz2}, 32'd0);
        chk("fwd2_x9", fwd2, 32'h0000_0099);
`else
        chk("hz2_x9_commit", {31'b0, hz2}, 32'd1);
`endif
        tick;
        issue_valid = 1'b0;
        #1 chk("hz2_x9_cnt1", {31'b0, hz2}, 32'd1);

        // single outstanding write to x4
        iss(4);
        rs1 = 5'd4;
        rd_a[0] = 5'd4; dat_a[0] = 32'hA5A5_A5A5;
        req(3'b001, 3'b001); tick;
        req_valid = '0;
        #1;
`ifdef WB_BYPASS_EN
        chk("hz1_x4_bypass", {31'b0, hz1}, 32'd0);
        chk("fwd1_x4", fwd1, 32'hA5A5_A5A5);
`else
        chk("hz1_x4_commit", {31'b0, hz1}, 32'd1);
`endif
        tick;
        #1 chk("hz1_x4_clear", {31'b0, hz1}, 32'd0);

        // reset mid-operation with a grant and an issue in flight
        rs1 = 5'd3; rs2 = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd8;
        rd_a[1] = 5'd8; dat_a[1] = 32'h0000_0088;
        req_valid = 3'b010;
        reset = 1'b1;
        tick;
        reset = 1'b0; req_valid = '0; issue_valid = 1'b0; issue_rd = 5'd3;
        #1 chk("mid_rst_wr_enable", {31'b0, wr_enable}, 32'd0);
        chk("mid_rst_wr_rd", {27'b0, wr_rd}, 32'd0);
        chk("mid_rst_wr_data", wr_data, 32'd0);
        chk("mid_rst_hz1", {31'b0, hz1}, 32'd0);
        chk("mid_rst_hz2", {31'b0, hz2}, 32'd0);
        chk("mid_rst_issue_x3", {31'b0, issue_ready}, 32'd1);
`ifdef WB_BYPASS_EN
        chk("mid_rst_fwd1", fwd1, 32'd0);
`endif
        tick;
        iss(5); iss(6); iss(7);
        rd_a = '{5'd5, 5'd6, 5'd7};
        dat_a = '{32'h0000_0505, 32'h0000_0606, 32'h0000_0707};
        req(3'b111, 3'b001); tick;
        req(3'b110, 3'b010); tick;
        req(3'b100, 3'b100); tick;
        req_valid = '0;
        repeat (3) tick;
        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
